// File: rtl/alu_op_sequencer_if.sv
// Request, result and adder-operand signals of the ALU op sequencer.
// The slave side is the sequencer; the master side is the requester/consumer plus the adder.
interface alu_op_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] add_bit1;
    logic [3:0] add_bit2;
    logic [4:0] add_sum;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;

    modport master (
        output in_valid, op, a, b, add_sum, out_ready,
        input  in_ready, add_bit1, add_bit2, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, op, a, b, add_sum, out_ready,
        output in_ready, add_bit1, add_bit2, out_valid, result, carry, zero
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences ADD/SUB/INC/MUL through an external 4-bit adder, one pass per cycle.
// Latency: out_valid rises N edges after accept (ADD/INC 1, SUB 2, MUL 4).
// Backpressure: result held in DONE until out_ready; in_ready low whenever not IDLE.
module alu_op_sequencer #(
    parameter bit MUL_EN = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    state_t     state, state_nxt;
    logic [1:0] op_q, pass_q, last_q;
    logic [3:0] a_q, hi_q, lo_q;
    logic       c1_q;
    logic [7:0] result_q;
    logic       carry_q, zero_q;

    logic       in_ready_c;
    logic [3:0] bit1_c, bit2_c;
    logic [1:0] eff_op;
    logic       accept, last_pass;
    logic [7:0] mul_shift;
    logic [7:0] res_nxt;
    logic       carry_nxt;

    assign accept    = bus.in_valid & in_ready_c;
    assign last_pass = (pass_q == last_q);
    // {hi,lo} after one shift-add step: {add_sum, lo} >> 1
    assign mul_shift = {bus.add_sum, lo_q[3:1]};
    assign eff_op    = (bus.op == OP_MUL && !MUL_EN) ? OP_ADD : bus.op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        bit1_c     = 4'd0;
        bit2_c     = 4'd0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                case (op_q)
                    OP_ADD: begin bit1_c = a_q; bit2_c = lo_q; end
                    OP_SUB: begin
                        // pass 0 forms A + ~B, pass 1 adds the +1
                        if (pass_q == 2'd0) begin bit1_c = a_q;  bit2_c = ~lo_q; end
                        else                begin bit1_c = hi_q; bit2_c = 4'd1;  end
                    end
                    OP_MUL:  begin bit1_c = hi_q; bit2_c = lo_q[0] ? a_q : 4'd0; end
                    default: begin bit1_c = a_q;  bit2_c = 4'd1; end
                endcase
                if (last_pass) state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        res_nxt   = 8'd0;
        carry_nxt = 1'b0;
        case (op_q)
            OP_SUB: begin
                res_nxt   = {4'd0, bus.add_sum[3:0]};
                carry_nxt = c1_q | bus.add_sum[4];
            end
            OP_MUL: begin
                res_nxt   = mul_shift;
                carry_nxt = |mul_shift[7:4];
            end
            default: begin
                res_nxt   = {3'd0, bus.add_sum};
                carry_nxt = bus.add_sum[4];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_ADD;
            pass_q   <= 2'd0;
            last_q   <= 2'd0;
            a_q      <= 4'd0;
            hi_q     <= 4'd0;
            lo_q     <= 4'd0;
            c1_q     <= 1'b0;
            result_q <= 8'd0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            op_q   <= eff_op;
            a_q    <= bus.a;
            lo_q   <= bus.b;
            hi_q   <= 4'd0;
            c1_q   <= 1'b0;
            pass_q <= 2'd0;
            case (eff_op)
                OP_SUB:  last_q <= 2'd1;
                OP_MUL:  last_q <= 2'd3;
                default: last_q <= 2'd0;
            endcase
        end else if (state == RUN) begin
            pass_q <= pass_q + 2'd1;
            if (op_q == OP_MUL) begin
                hi_q <= mul_shift[7:4];
                lo_q <= mul_shift[3:0];
            end else if (op_q == OP_SUB && pass_q == 2'd0) begin
                hi_q <= bus.add_sum[3:0];
                c1_q <= bus.add_sum[4];
            end
            if (last_pass) begin
                result_q <= res_nxt;
                carry_q  <= carry_nxt;
                zero_q   <= (res_nxt == 8'd0);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.add_bit1  = bit1_c;
    assign bus.add_bit2  = bit2_c;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
endmodule
